acs_array_pipe: RTL and testbench

- Full add-compare-select array for a rate-1/2 hard-decision Viterbi decoder, generalised over constraint length K (2^(K-1) states) and path-metric width.
- Holds all path metrics (PMs) in registers and updates them once per accepted received symbol.
- Outputs one survivor decision bit per state, plus the best state and its metric, to the traceback unit.
- Includes saturation, automatic normalisation and a frame-start clear, none of which the single-node 4-state ACS has.

---
 rtl/acs_array_pipe.sv | 134 +++++++++++++
 tb/tb_acs_array_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acs_array_pipe.sv
// rtl/acs_array_pipe.sv - Viterbi add-compare-select array with saturation, normalisation and frame clear
module acs_array_pipe #(
    parameter int             K         = 3,
    parameter int             PM_W      = 7,
    parameter logic [K-1:0]   G0        = 3'b111,
    parameter logic [K-1:0]   G1        = 3'b101,
    parameter int             INIT_BIAS = 16,
    localparam int            NS        = 1 << (K - 1),
    localparam int            SW        = K - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_clr,
    input  logic                 in_valid,
    input  logic [1:0]           data_recv,
    output logic                 dec_valid,
    output logic [NS-1:0]        dec,
    output logic [SW-1:0]        best_state,
    output logic [PM_W-1:0]      best_metric,
    output logic                 norm_event,
    output logic [NS*PM_W-1:0]   pm_out
);

    localparam logic [PM_W-1:0] HALF = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [PM_W-1:0] BIAS = PM_W'(INIT_BIAS);

    logic [PM_W-1:0] pm     [NS];
    logic [PM_W-1:0] acs_pm [NS];
    logic [PM_W-1:0] upd_pm [NS];
    logic [NS-1:0]   acs_dec;
    logic            all_high;
    logic [SW-1:0]   upd_best_state;
    logic [PM_W-1:0] upd_best_metric;

    // Branch metric, saturating add and compare/select for every next state
    always_comb begin
        logic [SW-1:0]   ns, p0, p1;
        logic [K-1:0]    r0, r1;
        logic [1:0]      bm0, bm1;
        logic [PM_W:0]   sum0, sum1;
        logic [PM_W-1:0] cand0, cand1;
        ns       = '0;
        p0       = '0;
        p1       = '0;
        r0       = '0;
        r1       = '0;
        bm0      = '0;
        bm1      = '0;
        sum0     = '0;
        sum1     = '0;
        cand0    = '0;
        cand1    = '0;
        acs_dec  = '0;
        all_high = 1'b1;
        for (int n = 0; n < NS; n++) begin
            ns   = SW'(n);
            p0   = {ns[SW-2:0], 1'b0};
            p1   = {ns[SW-2:0], 1'b1};
            // encoder register for the branch: newest input bit on the MSB
            r0   = {ns[SW-1], p0};
            r1   = {ns[SW-1], p1};
            bm0  = {1'b0, (^(G0 & r0)) ^ data_recv[1]} + {1'b0, (^(G1 & r0)) ^ data_recv[0]};
            bm1  = {1'b0, (^(G0 & r1)) ^ data_recv[1]} + {1'b0, (^(G1 & r1)) ^ data_recv[0]};
            sum0 = {1'b0, pm[p0]} + {{(PM_W-1){1'b0}}, bm0};
            sum1 = {1'b0, pm[p1]} + {{(PM_W-1){1'b0}}, bm1};
            cand0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
            cand1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
            // ties keep the even predecessor
            if (cand1 < cand0) begin
                acs_pm[n]  = cand1;
                acs_dec[n] = 1'b1;
            end else begin
                acs_pm[n]  = cand0;
            end
            if (!acs_pm[n][PM_W-1]) begin
                all_high = 1'b0;
            end
        end
    end

    // Normalise when every metric sits in the upper half, then find the lowest-index minimum
    always_comb begin
        upd_best_state = '0;
        for (int n = 0; n < NS; n++) begin
            upd_pm[n] = all_high ? (acs_pm[n] - HALF) : acs_pm[n];
        end
        upd_best_metric = upd_pm[0];
        for (int n = 1; n < NS; n++) begin
            if (upd_pm[n] < upd_best_metric) begin
                upd_best_metric = upd_pm[n];
                upd_best_state  = SW'(n);
            end
        end
    end

    // Single register stage: metrics and the decision bundle for the traceback unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) begin
                pm[s] <= (s == 0) ? '0 : BIAS;
            end
            dec_valid   <= 1'b0;
            dec         <= '0;
            best_state  <= '0;
            best_metric <= '0;
            norm_event  <= 1'b0;
        end else if (sync_clr) begin
            for (int s = 0; s < NS; s++) begin
                pm[s] <= (s == 0) ? '0 : BIAS;
            end
            dec_valid <= 1'b0;
        end else if (in_valid) begin
            for (int s = 0; s < NS; s++) begin
                pm[s] <= upd_pm[s];
            end
            dec_valid   <= 1'b1;
            dec         <= acs_dec;
            best_state  <= upd_best_state;
            best_metric <= upd_best_metric;
            norm_event  <= all_high;
        end else begin
            dec_valid <= 1'b0;
        end
    end

    // Flatten the metric registers onto the output bus
    always_comb begin
        pm_out = '0;
        for (int s = 0; s < NS; s++) begin
            pm_out[s*PM_W +: PM_W] = pm[s];
        end
    end

endmodule

// File: tb/tb_acs_array_pipe.sv
// tb/tb_acs_array_pipe.sv - Scoreboard bench for acs_array_pipe
module tb_acs_array_pipe;

    typedef struct packed {
        logic [27:0] pm;
        logic [3:0]  dec;
        logic [1:0]  bs;
        logic [6:0]  bm;
        logic        norm;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclr  = 1'b0;
    logic        in1   = 1'b0;
    logic        in2   = 1'b0;
    logic [1:0]  d1    = 2'b00;
    logic [1:0]  d2    = 2'b00;

    logic        dv1, dv2, ne1, ne2;
    logic [3:0]  dec1, dec2;
    logic [1:0]  bs1, bs2;
    logic [6:0]  bm1;
    logic [4:0]  bm2;
    logic [27:0] pm_out1;
    logic [19:0] pm_out2;

    int   total    = 0;
    int   bad      = 0;
    int   pulses1  = 0;
    int   norm_cnt = 0;
    int   mpm [4];
    exp_t q1 [$];
    exp_t q2 [$];

    acs_array_pipe #(.K(3), .PM_W(7), .G0(3'b111), .G1(3'b101), .INIT_BIAS(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sclr), .in_valid(in1), .data_recv(d1),
        .dec_valid(dv1), .dec(dec1), .best_state(bs1), .best_metric(bm1),
        .norm_event(ne1), .pm_out(pm_out1)
    );

    acs_array_pipe #(.K(3), .PM_W(5), .G0(3'b111), .G1(3'b101), .INIT_BIAS(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sclr), .in_valid(in2), .data_recv(d2),
        .dec_valid(dv2), .dec(dec2), .best_state(bs2), .best_metric(bm2),
        .norm_event(ne2), .pm_out(pm_out2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] pk(input int a3, input int a2, input int a1, input int a0);
        return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
    endfunction

    // Monitor for the 7-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (dv1) begin
            pulses1++;
            chk("m1_expected_pending", q1.size() != 0, 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("m1_pm", pm_out1, e.pm);
                chk("m1_dec", dec1, e.dec);
                chk("m1_best_state", bs1, e.bs);
                chk("m1_best_metric", bm1, e.bm);
                chk("m1_norm", ne1, e.norm);
            end
        end
    end

    // Monitor for the 5-bit instance
    always @(negedge clk) begin
        exp_t e;
        if (dv2) begin
            chk("m2_expected_pending", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("m2_pm", pm_out2, e.pm[19:0]);
                chk("m2_dec", dec2, e.dec);
                chk("m2_best_state", bs2, e.bs);
                chk("m2_best_metric", bm2, e.bm[4:0]);
                chk("m2_norm", ne2, e.norm);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in1 = 1'b0;
        in2 = 1'b0;
        sclr = 1'b0;
        #7;
        q1.delete();
        q2.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [1:0] sym, input int a3, input int a2, input int a1, input int a0,
                         input logic [3:0] dec, input int bs, input int bm);
        exp_t e;
        e.pm   = pk(a3, a2, a1, a0);
        e.dec  = dec;
        e.bs   = 2'(bs);
        e.bm   = 7'(bm);
        e.norm = 1'b0;
        q1.push_back(e);
        in1 = 1'b1;
        d1  = sym;
        @(posedge clk);
        #1;
        in1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Forward-trellis reference: each state s with input u feeds state {u, s[1]}
    task automatic model_step(input logic [1:0] sym, output exp_t e);
        int ce [4];
        int co [4];
        int nw [4];
        int c, bmv, ns;
        logic [2:0] r;
        logic all_hi;
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                ns  = u * 2 + s / 2;
                r   = 3'(u * 4 + s);
                bmv = 0;
                if ((^(r & 3'b111)) != sym[1]) bmv++;
                if ((^(r & 3'b101)) != sym[0]) bmv++;
                c = mpm[s] + bmv;
                if (c > 31) c = 31;
                if (s % 2 == 0) ce[ns] = c;
                else co[ns] = c;
            end
        end
        e = '0;
        all_hi = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (co[n] < ce[n]) begin
                nw[n] = co[n];
                e.dec[n] = 1'b1;
            end else begin
                nw[n] = ce[n];
            end
            if (nw[n] < 16) all_hi = 1'b0;
        end
        if (all_hi) begin
            norm_cnt++;
            for (int n = 0; n < 4; n++) nw[n] = nw[n] - 16;
        end
        e.norm = all_hi;
        e.bm   = 7'(nw[0]);
        e.bs   = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (nw[n] < int'(e.bm)) begin
                e.bm = 7'(nw[n]);
                e.bs = 2'(n);
            end
        end
        for (int n = 0; n < 4; n++) begin
            mpm[n] = nw[n];
            e.pm[n*5 +: 5] = 5'(nw[n]);
        end
    endtask

    initial begin
        int base;
        exp_t e;
        logic [1:0] sym;

        // reset state and the two single-symbol cases
        do_reset();
        chk("reset_pm", pm_out1, pk(16, 16, 16, 0));
        chk("reset_pm_w5", pm_out2, {5'd16, 5'd16, 5'd16, 5'd0});
        chk("reset_dec_valid", dv1, 0);
        chk("reset_dec", dec1, 0);
        chk("reset_best", {bs1, bm1, ne1}, 0);
        base = pulses1;
        step1(2'b00, 17, 2, 17, 0, 4'b0000, 0, 0);
        idle(1);
        chk("single_pulse_dv_low", dv1, 0);
        chk("single_pulse_count", pulses1 - base, 1);

        do_reset();
        step1(2'b11, 17, 0, 17, 2, 4'b0000, 2, 0);
        idle(1);

        // error-free codeword for bits 1,0,1,1,0,0 back-to-back
        do_reset();
        step1(2'b11, 17, 0, 17, 2, 4'b0000, 2, 0);
        step1(2'b10, 2, 3, 0, 3, 4'b0000, 1, 0);
        step1(2'b00, 3, 0, 3, 2, 4'b1111, 2, 0);
        step1(2'b01, 0, 3, 2, 3, 4'b0000, 3, 0);
        step1(2'b01, 2, 3, 0, 3, 4'b1111, 1, 0);
        step1(2'b11, 3, 2, 3, 0, 4'b1111, 0, 0);
        idle(1);

        // same codeword with the final symbol corrupted to 10
        do_reset();
        step1(2'b11, 17, 0, 17, 2, 4'b0000, 2, 0);
        step1(2'b10, 2, 3, 0, 3, 4'b0000, 1, 0);
        step1(2'b00, 3, 0, 3, 2, 4'b1111, 2, 0);
        step1(2'b01, 0, 3, 2, 3, 4'b0000, 3, 0);
        step1(2'b01, 2, 3, 0, 3, 4'b1111, 1, 0);
        step1(2'b10, 2, 1, 3, 1, 4'b1101, 0, 1);
        idle(1);

        // in_valid pattern 1,0,0,1 gives the same result as back-to-back
        do_reset();
        base = pulses1;
        step1(2'b11, 17, 0, 17, 2, 4'b0000, 2, 0);
        idle(1);
        chk("stall1_pm", pm_out1, pk(17, 0, 17, 2));
        chk("stall1_dv", dv1, 0);
        chk("stall1_best_hold", bs1, 2);
        idle(1);
        chk("stall2_pm", pm_out1, pk(17, 0, 17, 2));
        chk("stall2_dv", dv1, 0);
        step1(2'b10, 2, 3, 0, 3, 4'b0000, 1, 0);
        idle(1);
        chk("stall_pulse_count", pulses1 - base, 2);

        // sync_clr wins over a simultaneous symbol, then the frame restarts cleanly
        do_reset();
        step1(2'b11, 17, 0, 17, 2, 4'b0000, 2, 0);
        step1(2'b10, 2, 3, 0, 3, 4'b0000, 1, 0);
        sclr = 1'b1;
        in1  = 1'b1;
        d1   = 2'b00;
        @(posedge clk);
        #1;
        sclr = 1'b0;
        in1  = 1'b0;
        chk("sclr_pm", pm_out1, pk(16, 16, 16, 0));
        chk("sclr_dv", dv1, 0);
        step1(2'b00, 17, 2, 17, 0, 4'b0000, 0, 0);
        idle(1);

        // asynchronous reset between edges drops the pending update
        do_reset();
        step1(2'b11, 17, 0, 17, 2, 4'b0000, 2, 0);
        step1(2'b10, 2, 3, 0, 3, 4'b0000, 1, 0);
        step1(2'b00, 3, 0, 3, 2, 4'b1111, 2, 0);
        #2;
        rst_n = 1'b0;
        q1.delete();
        #1;
        chk("arst_pm", pm_out1, pk(16, 16, 16, 0));
        chk("arst_dv", dv1, 0);
        chk("arst_dec", dec1, 0);
        chk("arst_best_state", bs1, 0);
        chk("arst_best_metric_norm", {bm1, ne1}, 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 5-bit metrics: long symbol stream against the reference, forcing normalisation
        do_reset();
        mpm = '{0, 16, 16, 16};
        for (int i = 0; i < 300; i++) begin
            sym = 2'($urandom_range(0, 3));
            model_step(sym, e);
            q2.push_back(e);
            in2 = 1'b1;
            d2  = sym;
            @(posedge clk);
            #1;
            in2 = 1'b0;
            if (i % 9 == 4) idle(1);
        end
        idle(3);

        chk("norm_seen", norm_cnt > 0, 1);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
